fetch_inst_buffer: RTL and testbench

- Decoupling queue between the L1 instruction cache fetch stage and decode.
- Each cycle it accepts one fetch bundle of up to FETCH_WIDTH instructions, each with a per-lane valid bit and a PC.
- Valid lanes are compacted in lane order into a circular buffer. Up to DECODE_WIDTH oldest entries are presented to decode each cycle.
- Absorbs decode back-pressure and fetch bubbles. Supports a single-cycle flush on redirect.

---
 rtl/fetch_inst_buffer_pkg.sv | 22 ++
 rtl/fetch_inst_buffer_compact_idx.sv | 29 ++
 rtl/fetch_inst_buffer.sv | 113 +++++++++++
 tb/tb_fetch_inst_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_inst_buffer_pkg.sv
// Shared fetch typedefs and sizing constants for the fetch-to-decode instruction buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_inst_buffer_pkg;

    // Machine-wide fetch geometry
    localparam int FETCH_WIDTH      = 4;
    localparam int DECODE_WIDTH     = 4;
    localparam int SIZE_INSTRUCTION = 32;
    localparam int SIZE_PC          = 64;

    // Instruction buffer sizing
    localparam int IBUF_DEPTH = 16;

    // One buffered instruction with its PC and fetch exception flag
    typedef struct packed {
        logic [SIZE_INSTRUCTION-1:0] inst;
        logic [SIZE_PC-1:0]          pc;
        logic                        exc;
    } instBufEntry;

endpackage

// File: rtl/fetch_inst_buffer_compact_idx.sv
// Maps per-lane valid bits to compacted write offsets (exclusive prefix popcount) and lane total.
// Latency: purely combinational.
// Backpressure: none; caller masks the valid bits when the bundle is not accepted.
module inst_compact_idx
    import fetch_inst_buffer_pkg::*;
#(
    parameter int LANES = FETCH_WIDTH,
    parameter int OFF_W = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int CNT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]            laneValid,
    output logic [LANES-1:0][OFF_W-1:0] laneOffset,
    output logic [CNT_W-1:0]            numEnq
);

    logic [CNT_W-1:0] running;

    // Each lane's offset is the number of valid lanes below it
    always_comb begin
        running    = '0;
        laneOffset = '0;
        for (int i = 0; i < LANES; i++) begin
            laneOffset[i] = running[OFF_W-1:0];
            running       = running + CNT_W'(laneValid[i]);
        end
        numEnq = running;
    end

endmodule

// File: rtl/fetch_inst_buffer.sv
// Circular decoupling queue between I-cache fetch and decode; valid fetch lanes are compacted in order.
// Latency: 1 cycle from accepted bundle to visibility at the decode outputs, no empty bypass.
// Backpressure: fetchReady_o drops when fewer than FETCH_WIDTH slots are free; decode takes all or none.
module fetch_inst_buffer #(
    parameter int FETCH_WIDTH  = fetch_inst_buffer_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = fetch_inst_buffer_pkg::DECODE_WIDTH,
    parameter int DEPTH        = fetch_inst_buffer_pkg::IBUF_DEPTH,
    parameter int INST_W       = fetch_inst_buffer_pkg::SIZE_INSTRUCTION,
    parameter int PC_W         = fetch_inst_buffer_pkg::SIZE_PC,
    parameter int PTR_W        = $clog2(DEPTH),
    parameter int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush_i,
    input  logic                                fetchValid_i,
    input  logic [FETCH_WIDTH-1:0][INST_W-1:0]  inst_i,
    input  logic [FETCH_WIDTH-1:0][PC_W-1:0]    instPC_i,
    input  logic [FETCH_WIDTH-1:0]              instValid_i,
    input  logic                                instExc_i,
    output logic                                fetchReady_o,
    input  logic                                decodeReady_i,
    output logic [DECODE_WIDTH-1:0][INST_W-1:0] inst_o,
    output logic [DECODE_WIDTH-1:0][PC_W-1:0]   pc_o,
    output logic [DECODE_WIDTH-1:0]             exc_o,
    output logic [DECODE_WIDTH-1:0]             instValid_o,
    output logic [CNT_W-1:0]                    count_o
);

    import fetch_inst_buffer_pkg::*;

    localparam int OFF_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int ENQ_W = $clog2(FETCH_WIDTH + 1);

    instBufEntry entries [DEPTH];

    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] count;

    logic                                enq;
    logic [FETCH_WIDTH-1:0]              laneWrite;
    logic [FETCH_WIDTH-1:0][OFF_W-1:0]   laneOffset;
    logic [ENQ_W-1:0]                    numEnq;
    logic [CNT_W-1:0]                    nAvail;
    logic [CNT_W-1:0]                    nDeq;

    // Admission looks only at registered occupancy so fetch and decode handshakes stay loop-free
    assign fetchReady_o = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH);
    assign enq          = fetchValid_i & fetchReady_o & ~flush_i;
    assign laneWrite    = instValid_i & {FETCH_WIDTH{enq}};
    assign count_o      = count;

    inst_compact_idx #(
        .LANES (FETCH_WIDTH),
        .OFF_W (OFF_W),
        .CNT_W (ENQ_W)
    ) u_compact (
        .laneValid  (laneWrite),
        .laneOffset (laneOffset),
        .numEnq     (numEnq)
    );

    // Decode sees up to DECODE_WIDTH oldest entries and consumes all of them or none
    always_comb begin
        nAvail = (count < CNT_W'(DECODE_WIDTH)) ? count : CNT_W'(DECODE_WIDTH);
        nDeq   = (decodeReady_i & ~flush_i) ? nAvail : '0;
    end

    // Head-relative combinational read of the oldest entries
    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            inst_o[i]      = entries[headPtr + PTR_W'(i)].inst;
            pc_o[i]        = entries[headPtr + PTR_W'(i)].pc;
            exc_o[i]       = entries[headPtr + PTR_W'(i)].exc;
            instValid_o[i] = count > CNT_W'(i);
        end
    end

    // Write each accepted lane at tail plus its compacted offset; wraps naturally via pointer width
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (laneWrite[i]) begin
                entries[tailPtr + PTR_W'(laneOffset[i])] <= '{inst: inst_i[i], pc: instPC_i[i], exc: instExc_i};
            end
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats enqueue and dequeue
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (flush_i) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            headPtr <= headPtr + nDeq[PTR_W-1:0];
            tailPtr <= tailPtr + PTR_W'(numEnq);
            count   <= count + CNT_W'(numEnq) - nDeq;
        end
    end

    // Occupancy can never exceed capacity given the admission rule
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_fetch_inst_buffer.sv
module tb_fetch_inst_buffer;

    localparam int FW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush_i;
    logic                  fetchValid_i;
    logic [FW-1:0][31:0]   inst_i;
    logic [FW-1:0][63:0]   instPC_i;
    logic [FW-1:0]         instValid_i;
    logic                  instExc_i;
    logic                  fetchReady_o;
    logic                  decodeReady_i;
    logic [DW-1:0][31:0]   inst_o;
    logic [DW-1:0][63:0]   pc_o;
    logic [DW-1:0]         exc_o;
    logic [DW-1:0]         instValid_o;
    logic [4:0]            count_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        exc;
    } mEntry;

    mEntry q[$];

    always #5 clk = ~clk;

    fetch_inst_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .fetchValid_i  (fetchValid_i),
        .inst_i        (inst_i),
        .instPC_i      (instPC_i),
        .instValid_i   (instValid_i),
        .instExc_i     (instExc_i),
        .fetchReady_o  (fetchReady_o),
        .decodeReady_i (decodeReady_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .exc_o         (exc_o),
        .instValid_o   (instValid_o),
        .count_o       (count_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare every visible output with the reference queue
    task automatic checkAll();
        int sz;
        sz = q.size();
        chk("count", 64'(count_o), 64'(sz));
        chk("fetchReady", 64'(fetchReady_o), 64'((DEPTH - sz) >= FW));
        for (int i = 0; i < DW; i++) begin
            chk($sformatf("valid[%0d]", i), 64'(instValid_o[i]), 64'(i < sz));
            if (i < sz) begin
                chk($sformatf("inst[%0d]", i), 64'(inst_o[i]), 64'(q[i].inst));
                chk($sformatf("pc[%0d]", i), pc_o[i], q[i].pc);
                chk($sformatf("exc[%0d]", i), 64'(exc_o[i]), 64'(q[i].exc));
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the reference queue at the edge, then check
    task automatic drive(input logic fv, input logic [FW-1:0] vld, input logic [63:0] pcBase,
                         input logic ex, input logic dr, input logic fl, input logic rst);
        int  sz;
        bit  rdy;
        int  take;
        fetchValid_i  = fv;
        instValid_i   = vld;
        instExc_i     = ex;
        decodeReady_i = dr;
        flush_i       = fl;
        reset         = rst;
        for (int l = 0; l < FW; l++) begin
            inst_i[l]   = $urandom();
            instPC_i[l] = pcBase + 64'(4 * l);
        end
        @(posedge clk);
        sz  = q.size();
        rdy = (DEPTH - sz) >= FW;
        if (rst || fl) begin
            q.delete();
        end else begin
            if (dr) begin
                take = (sz < DW) ? sz : DW;
                repeat (take) void'(q.pop_front());
            end
            if (fv && rdy) begin
                for (int l = 0; l < FW; l++)
                    if (vld[l]) q.push_back('{inst_i[l], instPC_i[l], ex});
            end
        end
        #1;
        checkAll();
    endtask

    initial begin
        logic [63:0] pcNext;
        reset = 1'b1; flush_i = 1'b0; fetchValid_i = 1'b0; inst_i = '0;
        instPC_i = '0; instValid_i = '0; instExc_i = 1'b0; decodeReady_i = 1'b0;

        // Reset state
        drive(0, 4'b0000, 64'h0, 0, 0, 0, 1);
        drive(0, 4'b0000, 64'h0, 0, 0, 0, 1);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ready", 64'(fetchReady_o), 64'd1);
        chk("rst_valid", 64'(instValid_o), 64'd0);

        // Full bundle, no dequeue
        drive(1, 4'b1111, 64'h100, 0, 0, 0, 0);
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_valid", 64'(instValid_o), 64'hF);
        chk("full_pc0", pc_o[0], 64'h100);
        chk("full_pc3", pc_o[3], 64'h10C);

        // Sparse bundle is compacted
        drive(0, 4'b0000, 64'h0, 0, 0, 1, 0);
        drive(1, 4'b1010, 64'h200, 0, 0, 0, 0);
        chk("sparse_count", 64'(count_o), 64'd2);
        chk("sparse_pc0", pc_o[0], 64'h204);
        chk("sparse_pc1", pc_o[1], 64'h20C);
        chk("sparse_valid", 64'(instValid_o), 64'h3);

        // Fill to full, then overflow attempt is dropped
        drive(0, 4'b0000, 64'h0, 0, 0, 1, 0);
        for (int b = 0; b < 3; b++) drive(1, 4'b1111, 64'h300 + 64'(16 * b), 0, 0, 0, 0);
        chk("fill12_count", 64'(count_o), 64'd12);
        chk("fill12_ready", 64'(fetchReady_o), 64'd1);
        drive(1, 4'b1111, 64'h330, 0, 0, 0, 0);
        chk("fill16_count", 64'(count_o), 64'd16);
        chk("fill16_ready", 64'(fetchReady_o), 64'd0);
        drive(1, 4'b1111, 64'h340, 0, 0, 0, 0);
        chk("drop_count", 64'(count_o), 64'd16);
        chk("drop_pc0", pc_o[0], 64'h300);

        // Steady state across the wrap boundary
        drive(0, 4'b0000, 64'h0, 0, 0, 1, 0);
        drive(1, 4'b1111, 64'h400, 0, 0, 0, 0);
        drive(1, 4'b1111, 64'h410, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            drive(1, 4'b1111, 64'h420 + 64'(16 * c), 0, 1, 0, 0);
            chk("steady_count", 64'(count_o), 64'd8);
            chk("steady_pc0", pc_o[0], 64'h410 + 64'(16 * c));
        end

        // Flush at count 7 overrides same-cycle enqueue and dequeue
        drive(0, 4'b0000, 64'h0, 0, 0, 1, 0);
        drive(1, 4'b1111, 64'h500, 0, 0, 0, 0);
        drive(1, 4'b0111, 64'h510, 0, 0, 0, 0);
        chk("pre_flush_count", 64'(count_o), 64'd7);
        drive(1, 4'b1111, 64'h520, 0, 1, 1, 0);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(instValid_o), 64'd0);
        drive(0, 4'b0000, 64'h0, 0, 0, 0, 0);
        chk("flush_absent", 64'(count_o), 64'd0);

        // Reset at count 9 with a bundle present
        drive(1, 4'b1111, 64'h600, 0, 0, 0, 0);
        drive(1, 4'b1111, 64'h610, 0, 0, 0, 0);
        drive(1, 4'b0001, 64'h620, 0, 0, 0, 0);
        chk("pre_rst_count", 64'(count_o), 64'd9);
        drive(1, 4'b1111, 64'h630, 0, 0, 0, 1);
        chk("rst2_count", 64'(count_o), 64'd0);
        chk("rst2_ready", 64'(fetchReady_o), 64'd1);
        chk("rst2_valid", 64'(instValid_o), 64'd0);

        // Exception flag propagates
        drive(1, 4'b0001, 64'h700, 1, 0, 0, 0);
        chk("exc0", 64'(exc_o[0]), 64'd1);
        chk("exc_pc0", pc_o[0], 64'h700);

        // Randomized traffic against the reference queue
        pcNext = 64'h1000;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom()), pcNext, 1'($urandom()),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
            pcNext = pcNext + 64'h10;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
